// File: rtl/count_ctrl.sv
// ---------------------------------------------------------------------------------------------
// count_ctrl
//   Run/pause/clear sequencer for the seconds counter. It sits between the 1 Hz tick from the
//   frequency divider and the counter datapath. It decodes start/stop/clear requests and issues
//   single-cycle step (cnt_en) and load (cnt_ld) commands. When it sees the terminal count it
//   either parks in DONE or, with AUTO_RELOAD_EN defined, reloads the counter and keeps running.
//
//   Optional feature macro: AUTO_RELOAD_EN
//     defined   : a terminal tick in RUN pulses cnt_ld and wrap together and stays in RUN.
//                 DONE is unreachable.
//     undefined : a terminal tick in RUN goes to DONE. wrap is tied to 0.
//
// Parameters
//   WIDTH        width of i_count_val and o_ld_val
//   LIMIT        up-count terminal value and down-count load value
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_tick       1-cycle strobe from the divider, at most one every 2 clocks
//   i_start      level request; a rising edge starts or resumes counting
//   i_stop       level request; a rising edge pauses counting
//   i_clear      level request; a rising edge reloads the counter and returns to IDLE
//   i_dir_sel    1 = up, 0 = down; sampled only on a start from IDLE
//   i_count_val  current counter value, fed back from the counter
//   o_cnt_en     1-cycle step command
//   o_cnt_up     latched count direction
//   o_cnt_ld     1-cycle load command; the counter takes o_ld_val
//   o_ld_val     0 when counting up, LIMIT when counting down
//   o_busy       high in RUN
//   o_done       high in DONE
//   o_wrap       1-cycle terminal-reload strobe
//   o_state      IDLE = 00, RUN = 01, PAUSE = 10, DONE = 11
// ---------------------------------------------------------------------------------------------
module count_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 59
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clear,
  input  logic             i_dir_sel,
  input  logic [WIDTH-1:0] i_count_val,
  output logic             o_cnt_en,
  output logic             o_cnt_up,
  output logic             o_cnt_ld,
  output logic [WIDTH-1:0] o_ld_val,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wrap,
  output logic [1:0]       o_state
);

  localparam logic [WIDTH-1:0] LimitVal = WIDTH'(LIMIT);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e r_state;
  state_e w_state_d;

  // Previous request levels. They reset to 1 so a request held through reset is not an edge.
  logic r_start_prev;
  logic r_stop_prev;
  logic r_clear_prev;

  logic w_start_edge;
  logic w_stop_edge;
  logic w_clear_edge;
  logic w_terminal;

  logic             r_cnt_en;
  logic             r_cnt_up;
  logic             r_cnt_ld;
  logic [WIDTH-1:0] r_ld_val;
  logic             r_busy;
  logic             r_done;

  logic             w_cnt_en_d;
  logic             w_cnt_up_d;
  logic             w_cnt_ld_d;
  logic [WIDTH-1:0] w_ld_val_d;

  assign w_start_edge = i_start & ~r_start_prev;
  assign w_stop_edge  = i_stop & ~r_stop_prev;
  assign w_clear_edge = i_clear & ~r_clear_prev;

  assign w_terminal = r_cnt_up ? (i_count_val >= LimitVal) : (i_count_val == '0);

  // State register, request history and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_start_prev <= 1'b1;
      r_stop_prev  <= 1'b1;
      r_clear_prev <= 1'b1;
      r_cnt_en     <= 1'b0;
      r_cnt_up     <= 1'b1;
      r_cnt_ld     <= 1'b0;
      r_ld_val     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_start_prev <= i_start;
      r_stop_prev  <= i_stop;
      r_clear_prev <= i_clear;
      r_cnt_en     <= w_cnt_en_d;
      r_cnt_up     <= w_cnt_up_d;
      r_cnt_ld     <= w_cnt_ld_d;
      r_ld_val     <= w_ld_val_d;
      r_busy       <= (w_state_d == StRun);
      r_done       <= (w_state_d == StDone);
    end
  end

  // Next-state logic. Priority is clear > stop > start > tick; an event that has no meaning in
  // the current state does not mask the lower-priority ones.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_clear_edge) begin
          w_state_d = StIdle;
        end else if (w_start_edge) begin
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (w_clear_edge) begin
          w_state_d = StIdle;
        end else if (w_stop_edge) begin
          w_state_d = StPause;
        end else if (i_tick && w_terminal) begin
`ifdef AUTO_RELOAD_EN
          w_state_d = StRun;
`else
          w_state_d = StDone;
`endif
        end
      end
      StPause: begin
        if (w_clear_edge) begin
          w_state_d = StIdle;
        end else if (w_start_edge) begin
          w_state_d = StRun;
        end
      end
      StDone: begin
        if (w_clear_edge) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef AUTO_RELOAD_EN
  logic r_wrap;
  logic w_wrap_d;
`endif

  // Output logic: next values of the registered command outputs.
  always_comb begin
    w_cnt_en_d = 1'b0;
    w_cnt_ld_d = 1'b0;
    w_cnt_up_d = r_cnt_up;
`ifdef AUTO_RELOAD_EN
    w_wrap_d   = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_clear_edge) begin
          w_cnt_ld_d = 1'b1;
        end else if (w_start_edge) begin
          w_cnt_up_d = i_dir_sel;
        end
      end
      StRun: begin
        if (w_clear_edge) begin
          w_cnt_ld_d = 1'b1;
        end else if (!w_stop_edge && i_tick) begin
          if (!w_terminal) begin
            w_cnt_en_d = 1'b1;
          end else begin
`ifdef AUTO_RELOAD_EN
            w_cnt_ld_d = 1'b1;
            w_wrap_d   = 1'b1;
`endif
          end
        end
      end
      StPause, StDone: begin
        if (w_clear_edge) begin
          w_cnt_ld_d = 1'b1;
        end
      end
      default: w_cnt_ld_d = 1'b0;
    endcase
    // Load value follows the direction that will be in force alongside cnt_ld.
    w_ld_val_d = w_cnt_up_d ? '0 : LimitVal;
  end

`ifdef AUTO_RELOAD_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_d;
    end
  end
  assign o_wrap = r_wrap;
`else
  assign o_wrap = 1'b0;
`endif

  assign o_state  = r_state;
  assign o_cnt_en = r_cnt_en;
  assign o_cnt_up = r_cnt_up;
  assign o_cnt_ld = r_cnt_ld;
  assign o_ld_val = r_ld_val;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: a table of one-cycle vectors with hand-computed outputs,
// followed by a few multi-cycle sequences.
module tb_count_ctrl;

`ifdef AUTO_RELOAD_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick, start, stop, clear, dir_sel;
  logic [7:0] count_val;
  logic       cnt_en, cnt_up, cnt_ld, busy, done, wrap;
  logic [7:0] ld_val;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_ctrl #(
    .WIDTH(8),
    .LIMIT(59)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_tick     (tick),
    .i_start    (start),
    .i_stop     (stop),
    .i_clear    (clear),
    .i_dir_sel  (dir_sel),
    .i_count_val(count_val),
    .o_cnt_en   (cnt_en),
    .o_cnt_up   (cnt_up),
    .o_cnt_ld   (cnt_ld),
    .o_ld_val   (ld_val),
    .o_busy     (busy),
    .o_done     (done),
    .o_wrap     (wrap),
    .o_state    (state)
  );

  typedef struct {
    logic       rst, tick, start, stop, clear, dir;
    logic [7:0] cv;
    logic [1:0] st;
    logic       en, ld, up, busy, done, wrap;
    logic [7:0] ldv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_v, tick_v, start_v, stop_v, clear_v, dir_v,
                              input logic [7:0] cv_v, input logic [1:0] st_v,
                              input logic en_v, ld_v, up_v, busy_v, done_v, wrap_v,
                              input logic [7:0] ldv_v);
    vec_t v;
    v.rst = rst_v; v.tick = tick_v; v.start = start_v; v.stop = stop_v; v.clear = clear_v;
    v.dir = dir_v; v.cv = cv_v; v.st = st_v; v.en = en_v; v.ld = ld_v; v.up = up_v;
    v.busy = busy_v; v.done = done_v; v.wrap = wrap_v; v.ldv = ldv_v;
    return v;
  endfunction

  task automatic check_outs(input string name, input vec_t e);
    logic [15:0] act, exp;
    act = {state, cnt_en, cnt_ld, cnt_up, busy, done, wrap, ld_val};
    exp = {e.st, e.en, e.ld, e.up, e.busy, e.done, e.wrap, e.ldv};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%b en=%b ld=%b up=%b busy=%b done=%b wrap=%b ldv=%0d, want st=%b en=%b ld=%b up=%b busy=%b done=%b wrap=%b ldv=%0d",
               name, state, cnt_en, cnt_ld, cnt_up, busy, done, wrap, ld_val,
               e.st, e.en, e.ld, e.up, e.busy, e.done, e.wrap, e.ldv);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int pulses;
    int first_at;

    rst = 1'b1; tick = 1'b0; start = 1'b1; stop = 1'b0; clear = 1'b0; dir_sel = 1'b1;
    count_val = 8'd0;

    //                rst tk st sp cl dr cv     st    en ld up bs dn wr ldv
    // Reset with start held high, then three ticks: nothing happens.
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0,     2'd0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0,     2'd0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0,     2'd0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0,     2'd0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0,     2'd0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0,     2'd0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0,     2'd0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,     2'd0, 0, 0, 1, 0, 0, 0, 0));
    // Start up, three ticks at count 0,1,2.
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0,     2'd1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0,     2'd1, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,     2'd1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1,     2'd1, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1,     2'd1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 2,     2'd1, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2,     2'd1, 0, 0, 1, 1, 0, 0, 0));
    // Stop with a tick in the same cycle, tick ignored in PAUSE, resume with dir_sel = 0.
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 3,     2'd2, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3,     2'd2, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 3,     2'd2, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3,     2'd2, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 3,     2'd1, 0, 0, 1, 1, 0, 0, 0));
    // One below the limit still steps; at the limit it terminates.
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 58,    2'd1, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 59,    2'd1, 0, 0, 1, 1, 0, 0, 0));
    if (Auto) begin
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 59,  2'd1, 0, 1, 1, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 59,  2'd1, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0, 59,  2'd2, 0, 0, 1, 0, 0, 0, 0));
    end else begin
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 59,  2'd3, 0, 0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 59,  2'd3, 0, 0, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 0, 59,  2'd3, 0, 0, 1, 0, 1, 0, 0));
    end
    // Clear loads 0 for an up counter.
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 59,    2'd0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,     2'd0, 0, 0, 1, 0, 0, 0, 0));
    // Down count terminates at 0; clear loads LIMIT.
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     2'd1, 0, 0, 0, 1, 0, 0, 59));
    if (Auto) begin
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,   2'd1, 0, 1, 0, 1, 0, 1, 59));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   2'd1, 0, 0, 0, 1, 0, 0, 59));
    end else begin
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,   2'd3, 0, 0, 0, 0, 1, 0, 59));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,   2'd3, 0, 0, 0, 0, 1, 0, 59));
    end
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0,     2'd0, 0, 1, 0, 0, 0, 0, 59));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,     2'd0, 0, 0, 0, 0, 0, 0, 59));
    // Down count, non-terminal step; then clear and start edges together in RUN.
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,     2'd1, 0, 0, 0, 1, 0, 0, 59));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5,     2'd1, 1, 0, 0, 1, 0, 0, 59));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 5,     2'd0, 0, 1, 0, 0, 0, 0, 59));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 5,     2'd0, 0, 0, 0, 0, 0, 0, 59));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 5,     2'd0, 0, 0, 0, 0, 0, 0, 59));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 5,     2'd1, 0, 0, 1, 1, 0, 0, 0));
    // Reset mid-RUN with a tick: reset values, start held through reset is not an edge.
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 10,    2'd0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 10,    2'd0, 0, 0, 1, 0, 0, 0, 0));
    // Tick and stop ignored in IDLE; clear in IDLE pulses a load and stays IDLE.
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 10,    2'd0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 10,    2'd0, 0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 10,    2'd0, 0, 0, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; tick = vecs[i].tick; start = vecs[i].start; stop = vecs[i].stop;
      clear = vecs[i].clear; dir_sel = vecs[i].dir; count_val = vecs[i].cv;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i + 1), vecs[i]);
    end

    // Start up and wait (bounded) for busy.
    @(negedge clk);
    start = 1'b1; dir_sel = 1'b1; stop = 1'b0; clear = 1'b0; tick = 1'b0; rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!busy && n < 4);
    check_bit("busy_after_start", busy, 1'b1);
    check_bit("busy_latency_1", (n == 1), 1'b1);

    // One tick: cnt_en must be exactly one cycle wide, in the cycle after the tick.
    @(negedge clk);
    start = 1'b0; tick = 1'b1; count_val = 8'd0;
    @(negedge clk);
    tick = 1'b0;
    pulses = 0;
    first_at = -1;
    for (int k = 0; k < 4; k++) begin
      if (cnt_en) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
      @(negedge clk);
    end
    check_bit("en_single_pulse", (pulses == 1), 1'b1);
    check_bit("en_at_n_plus_1", (first_at == 0), 1'b1);

    // Clear in RUN: load pulse with ld_val 0, IDLE, then load drops.
    clear = 1'b1;
    @(negedge clk);
    check_bit("clr_ld", cnt_ld, 1'b1);
    check_bit("clr_ldv0", (ld_val == 8'd0), 1'b1);
    check_bit("clr_idle", (state == 2'b00), 1'b1);
    clear = 1'b0;
    @(negedge clk);
    check_bit("clr_ld_drop", cnt_ld, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
